// File: rtl/incond_pkg.sv
// Shared types and default constants for the Enter-button / switch-bank conditioner.
package incond_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int SW_WIDTH_DEF        = 10;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous inputs; 2-cycle latency, resets to 0, no backpressure.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/input_conditioner.sv
// Debounces the active-low Enter button (level + press pulse + switch snapshot) and syncs the switches.
// Press latency DEBOUNCE_CYCLES+3 edges; define INCOND_SW_DEBOUNCE_EN to also debounce the switches. No backpressure.
module input_conditioner
  import incond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SW_WIDTH        = SW_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                nEnter,
  input  logic [SW_WIDTH-1:0] switches_raw,
  output logic                Enter,
  output logic                EnterPulse,
  output logic [SW_WIDTH-1:0] switches,
  output logic [SW_WIDTH-1:0] sw_snap
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic                w_press_raw;
  logic                w_press_s;
  logic [SW_WIDTH-1:0] w_sw_s;

  btn_state_t          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_enter;
  logic                r_pulse;
  logic [SW_WIDTH-1:0] r_snap;

  assign w_press_raw = ~nEnter;

  sync2 #(.WIDTH(1)) u_sync_btn (
    .clk    (clk),
    .nreset (nreset),
    .i_d    (w_press_raw),
    .o_q    (w_press_s)
  );

  sync2 #(.WIDTH(SW_WIDTH)) u_sync_sw (
    .clk    (clk),
    .nreset (nreset),
    .i_d    (switches_raw),
    .o_q    (w_sw_s)
  );

  // Outputs are updated from the next state so Enter/EnterPulse line up with the state change.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_enter <= 1'b0;
      r_pulse <= 1'b0;
      r_snap  <= '0;
    end else begin
      r_pulse <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_press_s) begin
            r_state <= PRESS_WAIT;
            r_cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!w_press_s) begin
            r_state <= IDLE;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= PRESSED;
            r_enter <= 1'b1;
            r_pulse <= 1'b1;
            r_snap  <= switches;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!w_press_s) begin
            r_state <= RELEASE_WAIT;
            r_cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          // A return to pressed here is a release glitch: no new pulse.
          if (w_press_s) begin
            r_state <= PRESSED;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= IDLE;
            r_enter <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Enter      = r_enter;
  assign EnterPulse = r_pulse;
  assign sw_snap    = r_snap;

`ifdef INCOND_SW_DEBOUNCE_EN
  logic [SW_WIDTH-1:0] r_sw_cand;
  logic [SW_WIDTH-1:0] r_sw_out;
  logic [CNT_W-1:0]    r_sw_cnt;

  // Whole-vector debounce: any bit change restarts the shared stability count.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_sw_cand <= '0;
      r_sw_out  <= '0;
      r_sw_cnt  <= '0;
    end else if (w_sw_s != r_sw_cand) begin
      r_sw_cand <= w_sw_s;
      r_sw_cnt  <= '0;
    end else if (r_sw_cnt == CNT_LAST) begin
      r_sw_out <= r_sw_cand;
    end else begin
      r_sw_cnt <= r_sw_cnt + CNT_ONE;
    end
  end

  assign switches = r_sw_out;
`else
  assign switches = w_sw_s;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner with DEBOUNCE_CYCLES=4: directed stimulus queues expectations,
// a negedge monitor compares scheduled output samples and every EnterPulse against them.
module tb_input_conditioner;

  localparam int D = 4;
  localparam int W = 10;
`ifdef INCOND_SW_DEBOUNCE_EN
  localparam int SW_LAT = D + 3;
`else
  localparam int SW_LAT = 2;
`endif

  logic         clk = 1'b0;
  logic         nreset;
  logic         nEnter;
  logic [W-1:0] switches_raw;
  logic         Enter;
  logic         EnterPulse;
  logic [W-1:0] switches;
  logic [W-1:0] sw_snap;

  input_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .SW_WIDTH        (W)
  ) dut (
    .clk          (clk),
    .nreset       (nreset),
    .nEnter       (nEnter),
    .switches_raw (switches_raw),
    .Enter        (Enter),
    .EnterPulse   (EnterPulse),
    .switches     (switches),
    .sw_snap      (sw_snap)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far; stable when sampled on the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           at;
    string        name;
    logic         en;
    logic         pu;
    logic [W-1:0] sw;
    logic [W-1:0] snap;
  } chk_t;

  typedef struct {
    int           at;
    logic [W-1:0] snap;
  } pulse_t;

  chk_t   chk_q[$];
  pulse_t pulse_q[$];
  pulse_t mon_p;
  int     checks   = 0;
  int     failures = 0;

  task automatic expect_at(input int at, input string name, input logic en, input logic pu,
                           input logic [W-1:0] sw, input logic [W-1:0] snap);
    chk_t c;
    c.at = at; c.name = name; c.en = en; c.pu = pu; c.sw = sw; c.snap = snap;
    chk_q.push_back(c);
  endtask

  task automatic expect_pulse(input int at, input logic [W-1:0] snap);
    pulse_t p;
    p.at = at; p.snap = snap;
    pulse_q.push_back(p);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    for (int i = chk_q.size() - 1; i >= 0; i--) begin
      if (chk_q[i].at <= cyc) begin
        checks++;
        if (chk_q[i].at < cyc || Enter !== chk_q[i].en || EnterPulse !== chk_q[i].pu ||
            switches !== chk_q[i].sw || sw_snap !== chk_q[i].snap) begin
          failures++;
          $display("FAIL %s cyc=%0d got en=%b pu=%b sw=%h snap=%h want en=%b pu=%b sw=%h snap=%h (due cyc %0d)",
                   chk_q[i].name, cyc, Enter, EnterPulse, switches, sw_snap,
                   chk_q[i].en, chk_q[i].pu, chk_q[i].sw, chk_q[i].snap, chk_q[i].at);
        end
        chk_q.delete(i);
      end
    end
    if (EnterPulse !== 1'b0) begin
      checks++;
      if (pulse_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse cyc=%0d pulse=%b snap=%h, no pulse wanted", cyc, EnterPulse, sw_snap);
      end else begin
        mon_p = pulse_q.pop_front();
        if (mon_p.at != cyc || sw_snap !== mon_p.snap) begin
          failures++;
          $display("FAIL pulse cyc=%0d snap=%h, want cyc=%0d snap=%h", cyc, sw_snap, mon_p.at, mon_p.snap);
        end
      end
    end
  end

  int           t;
  int           r;
  logic [W-1:0] rst_sw6;
  logic [W-1:0] rst_snap;

  initial begin
    nreset       = 1'b0;
    nEnter       = 1'b1;
    switches_raw = '0;
    expect_at(2, "reset_hold", 0, 0, 10'h000, 10'h000);
    step(3);
    nreset = 1'b1;
    expect_at(cyc + 3, "after_reset", 0, 0, 10'h000, 10'h000);
    step(4);

    // Switch synchronizer latency, then a clean press capturing 0x0A5.
    switches_raw = 10'h0A5;
    t = cyc;
    expect_at(t + SW_LAT - 1, "sw_not_yet", 0, 0, 10'h000, 10'h000);
    expect_at(t + SW_LAT, "sw_sync", 0, 0, 10'h0A5, 10'h000);
    step(SW_LAT + 2);

    nEnter = 1'b0;
    t = cyc;
    expect_at(t + D + 2, "press_early", 0, 0, 10'h0A5, 10'h000);
    expect_at(t + D + 3, "press_rise", 1, 1, 10'h0A5, 10'h0A5);
    expect_pulse(t + D + 3, 10'h0A5);
    expect_at(t + D + 4, "pulse_fall", 1, 0, 10'h0A5, 10'h0A5);
    step(D + 5);

    switches_raw = 10'h3FF;
    t = cyc;
    expect_at(t + SW_LAT - 1, "sw_old_held", 1, 0, 10'h0A5, 10'h0A5);
    expect_at(t + SW_LAT, "snap_hold", 1, 0, 10'h3FF, 10'h0A5);
    step(SW_LAT + 2);

    nEnter = 1'b1;
    t = cyc;
    expect_at(t + D + 2, "release_early", 1, 0, 10'h3FF, 10'h0A5);
    expect_at(t + D + 3, "release_fall", 0, 0, 10'h3FF, 10'h0A5);
    step(D + 6);

    // Bounce: low 3, high 1, then low for good.
    nEnter = 1'b0;
    step(3);
    nEnter = 1'b1;
    step(1);
    nEnter = 1'b0;
    t = cyc;
    expect_at(t + D + 2, "bounce_early", 0, 0, 10'h3FF, 10'h0A5);
    expect_at(t + D + 3, "bounce_pulse", 1, 1, 10'h3FF, 10'h3FF);
    expect_pulse(t + D + 3, 10'h3FF);
    step(D + 6);

    // Release glitch of 2 cycles while pressed.
    t = cyc;
    nEnter = 1'b1;
    expect_at(t + 4, "glitch_a", 1, 0, 10'h3FF, 10'h3FF);
    expect_at(t + 6, "glitch_b", 1, 0, 10'h3FF, 10'h3FF);
    expect_at(t + 10, "glitch_c", 1, 0, 10'h3FF, 10'h3FF);
    step(2);
    nEnter = 1'b0;
    step(D + 8);

    nEnter = 1'b1;
    t = cyc;
    expect_at(t + D + 3, "release2_fall", 0, 0, 10'h3FF, 10'h3FF);
    step(D + 6);

    // Reset asserted mid PRESS_WAIT, released with the button still held.
    nEnter = 1'b0;
    t = cyc;
    step(4);
    expect_at(t + 5, "reset_async", 0, 0, 10'h000, 10'h000);
    expect_at(t + 6, "reset_held", 0, 0, 10'h000, 10'h000);
    @(posedge clk);
    #1 nreset = 1'b0;
    step(2);
    nreset = 1'b1;
    r = cyc;
    rst_sw6  = (SW_LAT <= D + 2) ? 10'h3FF : 10'h000;
    rst_snap = (SW_LAT <  D + 3) ? 10'h3FF : 10'h000;
    expect_at(r + D + 2, "rst_early", 0, 0, rst_sw6, 10'h000);
    expect_at(r + D + 3, "rst_pulse", 1, 1, 10'h3FF, rst_snap);
    expect_pulse(r + D + 3, rst_snap);
    expect_at(r + D + 4, "rst_pulse_fall", 1, 0, 10'h3FF, rst_snap);
    step(D + 6);

`ifdef INCOND_SW_DEBOUNCE_EN
    switches_raw = 10'h000;
    step(12);
    t = cyc;
    for (int k = 0; k < 4; k++) begin
      switches_raw = (k % 2 == 0) ? 10'h001 : 10'h000;
      step(2);
    end
    switches_raw = 10'h001;
    expect_at(t + 6, "swdb_toggle", 1, 0, 10'h000, rst_snap);
    t = cyc;
    expect_at(t + D + 2, "swdb_early", 1, 0, 10'h000, rst_snap);
    expect_at(t + D + 3, "swdb_settle", 1, 0, 10'h001, rst_snap);
    step(D + 6);
`endif

    step(3);
    for (int i = 0; i < chk_q.size(); i++) begin
      checks++;
      failures++;
      $display("FAIL never_checked %s due=%0d", chk_q[i].name, chk_q[i].at);
    end
    for (int i = 0; i < pulse_q.size(); i++) begin
      checks++;
      failures++;
      $display("FAIL missing_pulse got none, want pulse at cyc=%0d", pulse_q[i].at);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Front-end stage ahead of the ARM single-cycle processor top level. It converts the raw active-low Enter push-button and the raw slide-switch bank into clean, clock-synchronous signals. Outputs:
- a debounced level, and a single-cycle press pulse, for Enter;
- a synchronized (optionally debounced) switch vector;
- a snapshot of the switch vector taken on each press.

The processor's memory-mapped peripherals consume these outputs in place of the direct `~nEnter` inversion and raw switches.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: stable cycles required before a change is accepted (10 ms at 50 MHz); legal range ≥ 1.
- `SW_WIDTH`, default 10: switch bank width.

Ports:
- `clk` in 1: system clock, single clock domain.
- `nreset` in 1: reset, asynchronous assert, active-low.
- `nEnter` in 1: raw push-button, active-low, asynchronous to `clk`.
- `switches_raw` in SW_WIDTH: raw slide switches, asynchronous.
- `Enter` out 1: debounced button level, active-high.
- `EnterPulse` out 1: one-cycle pulse on each accepted press.
- `switches` out SW_WIDTH: conditioned switch vector.
- `sw_snap` out SW_WIDTH: value of `switches` captured on each accepted press.

## Operation
- Synchronization:
  - `press_s` = ~`nEnter` passed through a 2-flop synchronizer.
  - `switches_raw` passes through a 2-flop synchronizer per bit.
- Button FSM states are IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - IDLE: `press_s`=1 -> PRESS_WAIT, cnt←0.
  - PRESS_WAIT: `press_s`=0 -> IDLE. Else if cnt==DEBOUNCE_CYCLES-1 -> PRESSED. Else cnt←cnt+1.
  - PRESSED: `press_s`=0 -> RELEASE_WAIT, cnt←0.
  - RELEASE_WAIT: `press_s`=1 -> PRESSED (the glitch is absorbed, no new pulse). Else if cnt==DEBOUNCE_CYCLES-1 -> IDLE. Else cnt←cnt+1.
- Button outputs:
  - `Enter` = registered (state∈{PRESSED, RELEASE_WAIT}).
  - `EnterPulse` is registered. It is 1 only in the cycle after the PRESS_WAIT->PRESSED transition, and never asserts twice without an intervening return to IDLE.
- Snapshot: `sw_snap`←`switches` on the same edge as the PRESS_WAIT->PRESSED transition. It holds until the next accepted press.
- Reset values: all outputs are 0, synchronizers hold "released"/0, state is IDLE, cnt is 0.
- Reset mid-operation clears everything immediately. If the button is still held when reset releases, a full debounce runs and a fresh `EnterPulse` is produced.

## Timing
- Press latency: `nEnter` goes low and stays low before edge 1. Then `Enter` and `EnterPulse` rise after edge DEBOUNCE_CYCLES+3. `EnterPulse` falls after edge DEBOUNCE_CYCLES+4.
- Release latency is symmetric: `Enter` falls after edge DEBOUNCE_CYCLES+3, counted from the first edge that samples release.
- Any bounce shorter than DEBOUNCE_CYCLES restarts the wait and produces no output change.
- Switch latency: 2 edges without `INCOND_SW_DEBOUNCE_EN`, DEBOUNCE_CYCLES+3 edges with it.
- The snapshot is visible in the same cycle that `EnterPulse` is high.

## Configuration
- `INCOND_SW_DEBOUNCE_EN` defined: `switches` is debounced as a whole vector.
  - A candidate register and a shared counter are used.
  - Any change in the synchronized vector reloads the candidate and clears the counter.
  - `switches`←candidate once it has been unchanged for DEBOUNCE_CYCLES cycles.
- `INCOND_SW_DEBOUNCE_EN` undefined: `switches` = synchronizer output, and no switch counter is built.

## Structure
- `incond_pkg`: `btn_state_t` enum (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT) and the default constants for DEBOUNCE_CYCLES and SW_WIDTH.
- Sub-module `sync2`, parameterized by width, with a 2-flop reset-to-0 synchronizer. It is instantiated once for the button (width 1) and once for the switches.
- FSM, counters and output registers live in `input_conditioner`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Clean press: `nEnter` 1->0 and held. -> `Enter`=1 and a single `EnterPulse` after edge 7. Release -> `Enter`=0 after edge 7 from release, no pulse.
- Bounce: `nEnter` low for 3 cycles, high for 1, then low steadily. -> no pulse during the bounce; exactly one pulse 7 edges after the last falling transition.
- Release glitch: while PRESSED, `nEnter` goes high for 2 cycles then returns low. -> `Enter` stays 1 and there is no second pulse.
- Snapshot: `switches_raw`=10'h0A5, settled, then press. -> `sw_snap`=10'h0A5 in the pulse cycle. Change the switches to 10'h3FF while held -> `sw_snap` stays 10'h0A5.
- Reset mid-press: assert `nreset` in PRESS_WAIT. -> all outputs 0 immediately. Release reset with the button held -> pulse after 7 edges.
- With `INCOND_SW_DEBOUNCE_EN`: the switches toggle 0x001/0x000 every 2 cycles, then settle at 0x001. -> `switches` stays 0 until 7 edges after settling, then becomes 0x001.
